// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit between the pipeline and a word-wide data memory.
// Define MEM_ACCESS_STATS_EN to build the completed-load/store counters; otherwise they read 0.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [11:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic [31:0] dm_rdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_exc,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores
);

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic [11:0] dm_addr_q, dm_addr_d;
  logic [31:0] dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_exc_q, resp_exc_d;

  logic        req_store_s, align_bad_s, range_bad_s, req_bad_s;
  logic [3:0]  req_be_s;
  logic [31:0] req_wdata_s;
  logic        op_store_s;
  logic [15:0] half_s;
  logic [7:0]  byte_s;
  logic [31:0] load_data_s;

  // Decode the incoming request: alignment/range check and store lane placement.
  always_comb begin
    req_store_s = 1'b0;
    align_bad_s = 1'b0;
    req_be_s    = 4'b0000;
    req_wdata_s = 32'd0;
    case (req_op)
      OP_LW:         align_bad_s = (req_addr[1:0] != 2'b00);
      OP_LH, OP_LHU: align_bad_s = req_addr[0];
      OP_LB, OP_LBU: align_bad_s = 1'b0;
      OP_SW: begin
        req_store_s = 1'b1;
        align_bad_s = (req_addr[1:0] != 2'b00);
        req_be_s    = 4'b1111;
        req_wdata_s = req_wdata;
      end
      OP_SH: begin
        req_store_s = 1'b1;
        align_bad_s = req_addr[0];
        req_be_s    = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_s = {2{req_wdata[15:0]}};
      end
      OP_SB: begin
        req_store_s = 1'b1;
        req_be_s    = 4'b0001 << req_addr[1:0];
        req_wdata_s = {4{req_wdata[7:0]}};
      end
      default: align_bad_s = 1'b1;
    endcase
    range_bad_s = (req_addr >= 32'h0000_4000);
    req_bad_s   = align_bad_s | range_bad_s;
  end

  // Select and extend the addressed lane of the memory word for loads.
  always_comb begin
    op_store_s = op_q[2] & (op_q[1] | op_q[0]);
    half_s     = lo_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (lo_q)
      2'd0:    byte_s = dm_rdata[7:0];
      2'd1:    byte_s = dm_rdata[15:8];
      2'd2:    byte_s = dm_rdata[23:16];
      2'd3:    byte_s = dm_rdata[31:24];
      default: byte_s = 8'd0;
    endcase
    case (op_q)
      OP_LW:   load_data_s = dm_rdata;
      OP_LH:   load_data_s = {{16{half_s[15]}}, half_s};
      OP_LHU:  load_data_s = {16'd0, half_s};
      OP_LB:   load_data_s = {{24{byte_s[7]}}, byte_s};
      OP_LBU:  load_data_s = {24'd0, byte_s};
      default: load_data_s = 32'd0;
    endcase
  end

  // Next-state and registered-output logic; memory strobes are set up at accept so
  // they are flop outputs throughout ACCESS and drop the moment reset asserts.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lo_d         = lo_q;
    dm_addr_d    = dm_addr_q;
    dm_wdata_d   = dm_wdata_q;
    dm_be_d      = 4'b0000;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_exc_d   = resp_exc_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d       = req_op;
          lo_d       = req_addr[1:0];
          dm_addr_d  = req_addr[13:2];
          dm_wdata_d = req_wdata_s;
          if (req_bad_s) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_exc_d   = req_store_s ? 2'b10 : 2'b01;
          end else begin
            state_d = S_ACCESS;
            dm_be_d = req_be_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = op_store_s ? 32'd0 : load_data_s;
        resp_exc_d   = 2'b00;
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      op_q         <= 3'd0;
      lo_q         <= 2'd0;
      dm_addr_q    <= 12'd0;
      dm_wdata_q   <= 32'd0;
      dm_be_q      <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_exc_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lo_q         <= lo_d;
      dm_addr_q    <= dm_addr_d;
      dm_wdata_q   <= dm_wdata_d;
      dm_be_q      <= dm_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_exc_q   <= resp_exc_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign dm_addr    = dm_addr_q;
  assign dm_wdata   = dm_wdata_q;
  assign dm_be      = dm_be_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_exc   = resp_exc_q;

`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stat_loads_q, stat_loads_d;
  logic [31:0] stat_stores_q, stat_stores_d;
  logic        consume_ok_s;

  // Count only responses the pipeline actually takes and that carry no exception.
  always_comb begin
    consume_ok_s  = (state_q == S_RESP) && resp_ready && (resp_exc_q == 2'b00);
    stat_loads_d  = stat_loads_q;
    stat_stores_d = stat_stores_q;
    if (consume_ok_s) begin
      if (op_store_s) begin
        stat_stores_d = stat_stores_q + 32'd1;
      end else begin
        stat_loads_d = stat_loads_q + 32'd1;
      end
    end else begin
      stat_loads_d = stat_loads_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_loads_q  <= 32'd0;
      stat_stores_q <= 32'd0;
    end else begin
      stat_loads_q  <= stat_loads_d;
      stat_stores_q <= stat_stores_d;
    end
  end

  assign stat_loads  = stat_loads_q;
  assign stat_stores = stat_stores_q;
`else
  assign stat_loads  = 32'd0;
  assign stat_stores = 32'd0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low; all state cleared while low.
REQ-003 SHALL have ports: req_valid  in  1  pipeline request present.
REQ-004 SHALL have ports: req_ready  out  1  unit can accept a request.
REQ-005 SHALL have ports: req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
REQ-006 SHALL have ports: req_addr  in  32  byte address.
REQ-007 SHALL have ports: req_wdata  in  32  store data, right-aligned.
REQ-008 SHALL have ports: dm_addr  out  12  word index to data memory.
REQ-009 SHALL have ports: dm_wdata  out  32  lane-replicated store data.
REQ-010 SHALL have ports: dm_be  out  4  byte enables; nonzero only during a store write cycle.
REQ-011 SHALL have ports: dm_rdata  in  32  combinational read word at dm_addr.
REQ-012 SHALL have ports: resp_valid  out  1  response present.
REQ-013 SHALL have ports: resp_ready  in  1  pipeline consumes response.
REQ-014 SHALL have ports: resp_rdata  out  32  extended load result; 0 for stores and exceptions.
REQ-015 SHALL have ports: resp_exc  out  2  00 none, 01 load address error, 10 store address error.
REQ-016 SHALL have ports: stat_loads, stat_stores  out  32 each  completed-access counters (see Configuration).

Function
REQ-017 SHALL implement FSM IDLE, ACCESS, RESP; req_ready = (state==IDLE).
REQ-018 SHALL, on req_valid && req_ready, register op/addr/wdata and go to ACCESS, or to RESP directly if the address is bad.
REQ-019 SHALL treat an address as bad if halfword ops have addr[0]=1, word ops have addr[1:0]!=00, or addr >= 32'h0000_4000.
REQ-020 SHALL, for a bad address, set resp_exc to 01 (loads) or 10 (stores), keep dm_be=0 throughout, and never write memory.
REQ-021 SHALL drive dm_addr = registered addr[13:2] in ACCESS; dm_addr value outside ACCESS is don't-care, dm_be=0 outside ACCESS.
REQ-022 SHALL, in ACCESS, for SW set be=1111, data=wdata; for SH set be=addr[1]?1100:0011, data={2{wdata[15:0]}}; for SB set be=0001<<addr[1:0], data={4{wdata[7:0]}}.
REQ-023 SHALL, in ACCESS for loads, capture at the clock edge: LW whole word; LH/LHU halfword addr[1] sign/zero-extended; LB/LBU byte addr[1:0] sign/zero-extended.
REQ-024 SHALL go ACCESS -> RESP unconditionally after one cycle; request-to-resp_valid latency is 2 cycles (1 for bad address).
REQ-025 SHALL hold resp_valid, resp_rdata, resp_exc stable in RESP until resp_ready=1, then return to IDLE on that edge.
REQ-026 SHALL not accept a new request in the cycle a response is consumed (req_ready rises the following cycle).
REQ-027 SHALL ignore req_* while not in IDLE.

Reset
REQ-028 SHALL, while reset=0, force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_exc=00, dm_be=0, dm_addr=0, dm_wdata=0, counters=0.
REQ-029 SHALL abandon any in-flight access on reset assertion; a store in ACCESS whose edge coincides with reset low SHALL NOT see dm_be asserted after reset.

Configuration
REQ-030 SHALL, with MEM_ACCESS_STATS_EN defined, increment stat_loads/stat_stores by 1 on each consumed non-exception load/store response, wrapping 32'hFFFF_FFFF -> 0.
REQ-031 SHALL, without MEM_ACCESS_STATS_EN, tie stat_loads and stat_stores to 0 with no counter registers.

Verification
REQ-032 SHALL cover: SB addr 0x0000_0013 data 0x0000_00A5 -> ACCESS dm_addr=0x004, dm_be=1000, dm_wdata=0xA5A5A5A5; resp_exc=00.
REQ-033 SHALL cover: memory word 0x8001_7F80 at index 5, LB addr 0x14 -> resp_rdata 0xFFFF_FF80; LBU addr 0x15 -> 0x0000_007F; LH addr 0x16 -> 0xFFFF_8001.
REQ-034 SHALL cover: LW addr 0x0000_0002 -> resp_exc=01, resp_valid one cycle after accept, dm_be never nonzero; SH addr 0x4000 -> resp_exc=10.
REQ-035 SHALL cover: resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0, extra requests ignored.
REQ-036 SHALL cover: reset driven low mid-ACCESS of SW -> outputs at reset values immediately, no dm_be pulse afterwards, req_ready=1 after release.
REQ-037 SHALL cover (MEM_ACCESS_STATS_EN): 3 good loads, 2 good stores, 1 bad load -> stat_loads=3, stat_stores=2; without macro both read 0.
